// File: rtl/reu_sdram_ctrl.sv
// ---------------------------------------------------------------------------
// reu_sdram_ctrl
// SDRAM controller for a C64 RAM Expansion Unit. One SDRAM operation (read,
// write or auto-refresh) is run per PHI2 cycle. All logic runs on C25M. Command
// pins are registered and decoded from the next state, so the pins always show
// the command belonging to the state currently held in r_state.
//
// Ports
//   i_c25m            system clock, rising edge
//   i_reset           synchronous active-high reset
//   i_phi2            C64 PHI2 (asynchronous), rising edge starts an operation
//   i_ramrd/i_ramwr   read / write request from the DMA sequencer
//   i_ra[23:0]        byte address: [23:22] bank, [21:10] row, [9:0] column
//   i_wd[7:0]         write data
//   o_rd[7:0]         read data register
//   o_ready           high once SDRAM initialisation has completed
//   o_ncs..o_nwe      SDRAM command pins
//   o_ba, o_a         SDRAM bank / address
//   o_dqm             SDRAM data mask
//   o_dqout, o_dqoe   SDRAM write data and its output enable
//   i_dqin[7:0]       SDRAM read data
// ---------------------------------------------------------------------------
module reu_sdram_ctrl #(
  parameter int unsigned INIT_CYCLES = 5000,
  parameter int unsigned INIT_REFS   = 8
) (
  input  logic        i_c25m,
  input  logic        i_reset,
  input  logic        i_phi2,
  input  logic        i_ramrd,
  input  logic        i_ramwr,
  input  logic [23:0] i_ra,
  input  logic [7:0]  i_wd,
  output logic [7:0]  o_rd,
  output logic        o_ready,
  output logic        o_ncs,
  output logic        o_nras,
  output logic        o_ncas,
  output logic        o_nwe,
  output logic [1:0]  o_ba,
  output logic [11:0] o_a,
  output logic        o_dqm,
  output logic [7:0]  o_dqout,
  output logic        o_dqoe,
  input  logic [7:0]  i_dqin
);

  localparam logic [12:0] INIT_LOAD = 13'(INIT_CYCLES);
  localparam logic [3:0]  REFS_LOAD = 4'(INIT_REFS - 1);

  // {nCS, nRAS, nCAS, nWE}
  localparam logic [3:0] CMD_NOP   = 4'b0111;
  localparam logic [3:0] CMD_ACT   = 4'b0011;
  localparam logic [3:0] CMD_READ  = 4'b0101;
  localparam logic [3:0] CMD_WRITE = 4'b0100;
  localparam logic [3:0] CMD_PRE   = 4'b0010;
  localparam logic [3:0] CMD_REF   = 4'b0001;
  localparam logic [3:0] CMD_MRS   = 4'b0000;
  localparam logic [3:0] CMD_DESEL = 4'b1111;

  typedef enum logic [3:0] {
    S_INIT_WAIT = 4'd0,
    S_INIT_PC   = 4'd1,
    S_INIT_REF  = 4'd2,
    S_INIT_MRS  = 4'd3,
    S_IDLE      = 4'd4,
    S_ACT       = 4'd5,
    S_RCD       = 4'd6,
    S_RW        = 4'd7,
    S_CL1       = 4'd8,
    S_CL2       = 4'd9,
    S_REF       = 4'd10,
    S_RFC       = 4'd11
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [12:0] r_cnt;
  logic [12:0] w_next_cnt;
  logic [3:0]  r_ref_cnt;
  logic [3:0]  w_next_ref;

  logic [1:0]  r_sync;
  logic        w_start;
  logic        w_load;
  logic [23:0] r_ra;
  logic [7:0]  r_wd;
  logic        r_wr;
  logic [7:0]  r_rd;
  logic        r_ready;
  logic [13:0] w_bank_row;

  logic [3:0]  w_cmd;
  logic [1:0]  w_ba;
  logic [11:0] w_a;
  logic        w_dqm;
  logic        w_dqoe;
  logic [7:0]  w_dqout;

  logic [3:0]  r_cmd;
  logic [1:0]  r_ba;
  logic [11:0] r_a;
  logic        r_dqm;
  logic        r_dqoe;
  logic [7:0]  r_dqout;

  // r_sync[0] is the first synchroniser stage, r_sync[1] holds its previous value
  assign w_start = r_sync[0] & ~r_sync[1];
  assign w_load  = (r_state == S_IDLE) && w_start;
  // ACT is only entered in the cycle the request is latched, so take the
  // address straight from the inputs then
  assign w_bank_row = w_load ? i_ra[23:10] : r_ra[23:10];

  // State register with counters
  always_ff @(posedge i_c25m) begin
    if (i_reset) begin
      r_state   <= S_INIT_WAIT;
      r_cnt     <= INIT_LOAD;
      r_ref_cnt <= REFS_LOAD;
    end else begin
      r_state   <= w_next_state;
      r_cnt     <= w_next_cnt;
      r_ref_cnt <= w_next_ref;
    end
  end

  // Next-state logic; counters only decrement while non-zero
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    w_next_ref   = r_ref_cnt;
    case (r_state)
      S_INIT_WAIT: begin
        if (r_cnt == 13'd0) begin
          w_next_state = S_INIT_PC;
          w_next_cnt   = 13'd1;
        end else begin
          w_next_cnt = r_cnt - 13'd1;
        end
      end
      S_INIT_PC: begin
        if (r_cnt == 13'd0) begin
          w_next_state = S_INIT_REF;
          w_next_cnt   = 13'd2;
          w_next_ref   = REFS_LOAD;
        end else begin
          w_next_cnt = r_cnt - 13'd1;
        end
      end
      S_INIT_REF: begin
        if (r_cnt == 13'd0) begin
          if (r_ref_cnt == 4'd0) begin
            w_next_state = S_INIT_MRS;
            w_next_cnt   = 13'd1;
          end else begin
            w_next_cnt = 13'd2;
            w_next_ref = r_ref_cnt - 4'd1;
          end
        end else begin
          w_next_cnt = r_cnt - 13'd1;
        end
      end
      S_INIT_MRS: begin
        if (r_cnt == 13'd0) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_cnt = r_cnt - 13'd1;
        end
      end
      S_IDLE: begin
        if (w_start) begin
          if (i_ramrd || i_ramwr) begin
            w_next_state = S_ACT;
          end else begin
            w_next_state = S_REF;
          end
        end else begin
          w_next_state = S_IDLE;
        end
      end
      S_ACT: w_next_state = S_RCD;
      S_RCD: w_next_state = S_RW;
      S_RW: begin
        if (r_wr) begin
          w_next_state = S_RFC;
          w_next_cnt   = 13'd1;
        end else begin
          w_next_state = S_CL1;
        end
      end
      S_CL1: w_next_state = S_CL2;
      // RFC doubles as the two-NOP write-recovery / precharge gap
      S_CL2, S_REF: begin
        w_next_state = S_RFC;
        w_next_cnt   = 13'd1;
      end
      S_RFC: begin
        if (r_cnt == 13'd0) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_cnt = r_cnt - 13'd1;
        end
      end
      default: begin
        w_next_state = S_INIT_WAIT;
        w_next_cnt   = INIT_LOAD;
        w_next_ref   = REFS_LOAD;
      end
    endcase
  end

  // Output decode from the next state; a command is issued on entry to its step
  always_comb begin
    w_cmd   = CMD_NOP;
    w_ba    = 2'd0;
    w_a     = 12'd0;
    w_dqm   = 1'b1;
    w_dqoe  = 1'b0;
    w_dqout = 8'd0;
    case (w_next_state)
      S_INIT_PC: begin
        if (w_next_cnt == 13'd1) begin
          w_cmd = CMD_PRE;
          w_a   = 12'h400;
        end else begin
          w_cmd = CMD_NOP;
        end
      end
      S_INIT_REF: begin
        if (w_next_cnt == 13'd2) begin
          w_cmd = CMD_REF;
        end else begin
          w_cmd = CMD_NOP;
        end
      end
      S_INIT_MRS: begin
        if (w_next_cnt == 13'd1) begin
          w_cmd = CMD_MRS;
          w_a   = 12'h020;
        end else begin
          w_cmd = CMD_NOP;
        end
      end
      S_ACT: begin
        w_cmd = CMD_ACT;
        w_ba  = w_bank_row[13:12];
        w_a   = w_bank_row[11:0];
      end
      S_RW: begin
        w_ba  = r_ra[23:22];
        w_a   = {2'b01, r_ra[9:0]};
        w_dqm = 1'b0;
        if (r_wr) begin
          w_cmd   = CMD_WRITE;
          w_dqoe  = 1'b1;
          w_dqout = r_wd;
        end else begin
          w_cmd = CMD_READ;
        end
      end
      S_CL1, S_CL2: w_dqm = 1'b0;
      S_REF:        w_cmd = CMD_REF;
      default:      w_cmd = CMD_NOP;
    endcase
  end

  // Registered SDRAM pins; reset deselects the device
  always_ff @(posedge i_c25m) begin
    if (i_reset) begin
      r_cmd   <= CMD_DESEL;
      r_ba    <= 2'd0;
      r_a     <= 12'd0;
      r_dqm   <= 1'b1;
      r_dqoe  <= 1'b0;
      r_dqout <= 8'd0;
    end else begin
      r_cmd   <= w_cmd;
      r_ba    <= w_ba;
      r_a     <= w_a;
      r_dqm   <= w_dqm;
      r_dqoe  <= w_dqoe;
      r_dqout <= w_dqout;
    end
  end

  // PHI2 synchroniser, request latch, read capture and ready flag
  always_ff @(posedge i_c25m) begin
    if (i_reset) begin
      r_sync  <= 2'b00;
      r_ra    <= 24'd0;
      r_wd    <= 8'd0;
      r_wr    <= 1'b0;
      r_rd    <= 8'd0;
      r_ready <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_phi2};
      if (w_load) begin
        r_ra <= i_ra;
        r_wd <= i_wd;
        // a simultaneous read+write request performs only the write
        r_wr <= i_ramwr;
      end
      // CAS latency 2: data for the READ is on DQ during CL2
      if (r_state == S_CL2) begin
        r_rd <= i_dqin;
      end
      r_ready <= r_ready | (w_next_state == S_IDLE);
    end
  end

  assign {o_ncs, o_nras, o_ncas, o_nwe} = r_cmd;
  assign o_ba    = r_ba;
  assign o_a     = r_a;
  assign o_dqm   = r_dqm;
  assign o_dqoe  = r_dqoe;
  assign o_dqout = r_dqout;
  assign o_rd    = r_rd;
  assign o_ready = r_ready;

endmodule

// File: tb/tb_reu_sdram_ctrl.sv
// Testbench for reu_sdram_ctrl: random and directed PHI2 cycles checked
// against a per-transaction command-train model and a byte-addressed memory.
module tb_reu_sdram_ctrl;

  localparam logic [3:0] C_NOP   = 4'b0111;
  localparam logic [3:0] C_ACT   = 4'b0011;
  localparam logic [3:0] C_READ  = 4'b0101;
  localparam logic [3:0] C_WRITE = 4'b0100;
  localparam logic [3:0] C_PRE   = 4'b0010;
  localparam logic [3:0] C_REF   = 4'b0001;
  localparam logic [3:0] C_MRS   = 4'b0000;
  localparam logic [3:0] C_DESEL = 4'b1111;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        phi2  = 1'b0;
  logic        ramrd = 1'b0;
  logic        ramwr = 1'b0;
  logic [23:0] ra    = 24'd0;
  logic [7:0]  wd    = 8'd0;
  logic [7:0]  dqin  = 8'd0;
  logic [7:0]  rd;
  logic        ready, ncs, nras, ncas, nwe, dqm, dqoe;
  logic [1:0]  ba;
  logic [11:0] a;
  logic [7:0]  dqout;
  logic [3:0]  cmd;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [7:0] ref_mem [int];
  int         written_q [$];
  logic [7:0] rd_exp = 8'h00;

  assign cmd = {ncs, nras, ncas, nwe};

  always #20 clk = ~clk;

  reu_sdram_ctrl #(.INIT_CYCLES(16), .INIT_REFS(2)) dut (
    .i_c25m(clk), .i_reset(reset), .i_phi2(phi2), .i_ramrd(ramrd), .i_ramwr(ramwr),
    .i_ra(ra), .i_wd(wd), .o_rd(rd), .o_ready(ready),
    .o_ncs(ncs), .o_nras(nras), .o_ncas(ncas), .o_nwe(nwe),
    .o_ba(ba), .o_a(a), .o_dqm(dqm), .o_dqout(dqout), .o_dqoe(dqoe), .i_dqin(dqin)
  );

  // SDRAM device model: bank/row/column storage, CAS latency 2, junk otherwise
  logic [7:0]  sd_mem [int];
  logic [11:0] open_row [4] = '{default: 12'h000};
  logic        d1_v = 1'b0, d2_v = 1'b0;
  logic [7:0]  d1 = 8'h00, d2 = 8'h00;
  always @(negedge clk) begin
    logic [7:0] nxt;
    int key;
    nxt  = d2_v ? d2 : 8'($urandom);
    d2_v = d1_v;
    d2   = d1;
    d1_v = 1'b0;
    key  = int'({ba, open_row[ba], a[9:0]});
    case (cmd)
      C_ACT:   open_row[ba] = a;
      C_WRITE: if (dqoe === 1'b1 && dqm === 1'b0) sd_mem[key] = dqout;
      C_READ: begin
        d1_v = 1'b1;
        d1   = sd_mem.exists(key) ? sd_mem[key] : 8'hEE;
      end
      default: ;
    endcase
    dqin = nxt;
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vectors++; if (cmd !== C_DESEL) begin miscompares++; $display("FAIL reset_cmd: got %b expected %b", cmd, C_DESEL); end
      vectors++; if (ba !== 2'd0)     begin miscompares++; $display("FAIL reset_ba: got %0d expected 0", ba); end
      vectors++; if (a !== 12'd0)     begin miscompares++; $display("FAIL reset_a: got %h expected 000", a); end
      vectors++; if (dqm !== 1'b1)    begin miscompares++; $display("FAIL reset_dqm: got %b expected 1", dqm); end
      vectors++; if (dqoe !== 1'b0)   begin miscompares++; $display("FAIL reset_dqoe: got %b expected 0", dqoe); end
      vectors++; if (dqout !== 8'd0)  begin miscompares++; $display("FAIL reset_dqout: got %h expected 00", dqout); end
      vectors++; if (rd !== 8'd0)     begin miscompares++; $display("FAIL reset_rd: got %h expected 00", rd); end
      vectors++; if (ready !== 1'b0)  begin miscompares++; $display("FAIL reset_ready: got %b expected 0", ready); end
    end
  endtask

  // Releases reset (caller holds it at a falling edge) and checks the whole
  // init train; PHI2 is toggled with a write request to show it is ignored.
  task automatic test_init(input string tag);
    logic [3:0]  ec [$];
    logic [11:0] ea [$];
    logic [11:0] em [$];
    for (int i = 0; i < 16; i++) begin ec.push_back(C_NOP); ea.push_back(12'h000); em.push_back(12'h000); end
    ec.push_back(C_PRE); ea.push_back(12'h400); em.push_back(12'h400);
    ec.push_back(C_NOP); ea.push_back(12'h000); em.push_back(12'h000);
    for (int r = 0; r < 2; r++) begin
      ec.push_back(C_REF); ea.push_back(12'h000); em.push_back(12'h000);
      ec.push_back(C_NOP); ea.push_back(12'h000); em.push_back(12'h000);
      ec.push_back(C_NOP); ea.push_back(12'h000); em.push_back(12'h000);
    end
    ec.push_back(C_MRS); ea.push_back(12'h020); em.push_back(12'hFFF);
    ec.push_back(C_NOP); ea.push_back(12'h000); em.push_back(12'h000);
    reset = 1'b0;
    ramwr = 1'b1;
    ra    = 24'h123456;
    for (int i = 0; i < ec.size(); i++) begin
      @(negedge clk);
      if (i == 5)  phi2 = 1'b1;
      if (i == 12) phi2 = 1'b0;
      vectors++; if (cmd !== ec[i]) begin miscompares++; $display("FAIL %s_cmd[%0d]: got %b expected %b", tag, i, cmd, ec[i]); end
      vectors++; if ((a & em[i]) !== ea[i]) begin miscompares++; $display("FAIL %s_a[%0d]: got %h expected %h", tag, i, a, ea[i]); end
      if (ec[i] == C_MRS) begin
        vectors++; if (ba !== 2'd0) begin miscompares++; $display("FAIL %s_mrs_ba: got %0d expected 0", tag, ba); end
      end
      vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL %s_ready_early[%0d]: got %b expected 0", tag, i, ready); end
      vectors++; if (dqoe !== 1'b0)  begin miscompares++; $display("FAIL %s_dqoe[%0d]: got %b expected 0", tag, i, dqoe); end
    end
    @(negedge clk);
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL %s_ready: got %b expected 1", tag, ready); end
    vectors++; if (cmd !== C_NOP)  begin miscompares++; $display("FAIL %s_idle_cmd: got %b expected %b", tag, cmd, C_NOP); end
    ramwr = 1'b0;
    phi2  = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // One full PHI2 cycle; expected command train derived from the request type
  task automatic do_op(input string tag, input bit r, input bit w, input logic [23:0] addr, input logic [7:0] data);
    logic [3:0]  c_log [16];
    logic [11:0] a_log [16];
    logic [1:0]  ba_log [16];
    logic        oe_log [16], dqm_log [16], rdy_log [16];
    logic [7:0]  do_log [16], rd_log [16];
    logic [3:0]  exp_cmd [$];
    logic [7:0]  rd_before, rd_after;
    int lat, d;
    if (w) begin
      exp_cmd.push_back(C_ACT); exp_cmd.push_back(C_NOP); exp_cmd.push_back(C_WRITE);
      exp_cmd.push_back(C_NOP); exp_cmd.push_back(C_NOP);
    end else if (r) begin
      exp_cmd.push_back(C_ACT); exp_cmd.push_back(C_NOP); exp_cmd.push_back(C_READ);
      for (int k = 0; k < 4; k++) exp_cmd.push_back(C_NOP);
    end else begin
      exp_cmd.push_back(C_REF); exp_cmd.push_back(C_NOP); exp_cmd.push_back(C_NOP);
    end
    rd_before = rd_exp;
    rd_after  = rd_before;
    if (w) begin
      ref_mem[int'(addr)] = data;
      written_q.push_back(int'(addr));
    end else if (r) begin
      rd_after = ref_mem.exists(int'(addr)) ? ref_mem[int'(addr)] : 8'hEE;
    end
    @(negedge clk);
    ramrd = r; ramwr = w; ra = addr; wd = data;
    d = $urandom_range(1, 18);
    if ($urandom_range(0, 1) == 1) d += 20;
    #(d) phi2 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      c_log[i] = cmd; a_log[i] = a; ba_log[i] = ba; oe_log[i] = dqoe; dqm_log[i] = dqm;
      rdy_log[i] = ready; do_log[i] = dqout; rd_log[i] = rd;
      if (i == 7) begin
        phi2 = 1'b0; ramrd = 1'b0; ramwr = 1'b0; ra = 24'($urandom); wd = 8'($urandom);
      end
    end
    lat = -1;
    for (int i = 0; i < 16; i++) if (lat < 0 && c_log[i] !== C_NOP) lat = i;
    vectors++;
    if (lat < 1 || lat > 3) begin
      miscompares++; $display("FAIL %s_latency: got %0d expected 1..3", tag, lat);
      rd_exp = rd_after;
      return;
    end
    for (int i = 0; i < 16; i++) begin
      int k;
      logic [3:0] ec;
      logic [7:0] er;
      k  = i - lat;
      ec = (k >= 0 && k < exp_cmd.size()) ? exp_cmd[k] : C_NOP;
      er = (r && !w && k >= 5) ? rd_after : rd_before;
      vectors++; if (c_log[i] !== ec) begin miscompares++; $display("FAIL %s_cmd[+%0d]: got %b expected %b", tag, k, c_log[i], ec); end
      vectors++; if (oe_log[i] !== (w && k == 2)) begin miscompares++; $display("FAIL %s_dqoe[+%0d]: got %b expected %b", tag, k, oe_log[i], (w && k == 2)); end
      vectors++; if (rd_log[i] !== er) begin miscompares++; $display("FAIL %s_rd[+%0d]: got %h expected %h", tag, k, rd_log[i], er); end
      vectors++; if (rdy_log[i] !== 1'b1) begin miscompares++; $display("FAIL %s_ready[+%0d]: got %b expected 1", tag, k, rdy_log[i]); end
      if ((r || w) && k == 0) begin
        vectors++; if (ba_log[i] !== addr[23:22]) begin miscompares++; $display("FAIL %s_act_ba: got %0d expected %0d", tag, ba_log[i], addr[23:22]); end
        vectors++; if (a_log[i] !== addr[21:10])  begin miscompares++; $display("FAIL %s_act_a: got %h expected %h", tag, a_log[i], addr[21:10]); end
      end
      if ((r || w) && k == 2) begin
        vectors++; if (ba_log[i] !== addr[23:22]) begin miscompares++; $display("FAIL %s_rw_ba: got %0d expected %0d", tag, ba_log[i], addr[23:22]); end
        vectors++; if (a_log[i] !== {2'b01, addr[9:0]}) begin miscompares++; $display("FAIL %s_rw_a: got %h expected %h", tag, a_log[i], {2'b01, addr[9:0]}); end
      end
      if (w && k == 2) begin
        vectors++; if (do_log[i] !== data) begin miscompares++; $display("FAIL %s_dqout: got %h expected %h", tag, do_log[i], data); end
      end
      if ((w && k == 2) || (r && !w && k >= 2 && k <= 4)) begin
        vectors++; if (dqm_log[i] !== 1'b0) begin miscompares++; $display("FAIL %s_dqm[+%0d]: got %b expected 0", tag, k, dqm_log[i]); end
      end
    end
    rd_exp = rd_after;
  endtask

  task automatic test_write_read();
    do_op("wr_c3a5f0", 1'b0, 1'b1, 24'hC3A5F0, 8'h5A);
    do_op("rd_c3a5f0", 1'b1, 1'b0, 24'hC3A5F0, 8'h00);
    for (int i = 0; i < 3; i++) do_op("rd_hold_ref", 1'b0, 1'b0, 24'($urandom), 8'($urandom));
  endtask

  task automatic test_refresh();
    for (int i = 0; i < 4; i++) do_op("refresh", 1'b0, 1'b0, 24'($urandom), 8'($urandom));
  endtask

  task automatic test_both();
    logic [23:0] ad;
    ad = 24'($urandom);
    do_op("both_wr", 1'b1, 1'b1, ad, 8'hA7);
    do_op("both_rdback", 1'b1, 1'b0, ad, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_op("rnd_ref", 1'b0, 1'b0, 24'($urandom), 8'($urandom));
        1: do_op("rnd_wr", 1'b0, 1'b1, 24'($urandom), 8'($urandom));
        2: do_op("rnd_rd", 1'b1, 1'b0, 24'(written_q[$urandom_range(0, written_q.size() - 1)]), 8'($urandom));
        default: do_op("rnd_both", 1'b1, 1'b1, 24'($urandom), 8'($urandom));
      endcase
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int d;
    found = 1'b0;
    @(negedge clk);
    ramrd = 1'b1; ramwr = 1'b0; ra = 24'(written_q[0]);
    d = $urandom_range(1, 18);
    #(d) phi2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (!found) begin
        @(negedge clk);
        if (cmd === C_READ) found = 1'b1;
      end
    end
    vectors++;
    if (!found) begin
      miscompares++; $display("FAIL midreset_read_seen: got none expected READ within 8 cycles");
    end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++; if (ncs !== 1'b1)   begin miscompares++; $display("FAIL midreset_ncs: got %b expected 1", ncs); end
    vectors++; if (dqoe !== 1'b0)  begin miscompares++; $display("FAIL midreset_dqoe: got %b expected 0", dqoe); end
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL midreset_ready: got %b expected 0", ready); end
    vectors++; if (rd !== 8'd0)    begin miscompares++; $display("FAIL midreset_rd: got %h expected 00", rd); end
    phi2 = 1'b0; ramrd = 1'b0;
    rd_exp = 8'h00;
    test_init("reinit");
    do_op("rd_after_reinit", 1'b1, 1'b0, 24'(written_q[0]), 8'h00);
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_write_read();
    test_refresh();
    test_both();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
